pc_ctrl: RTL and testbench

Fetch-side sequencer that owns the program counter and drives the instruction-memory fetch handshake. Selects the next PC by priority: exception/flush redirect, branch redirect, stall hold, sequential +4. Sits between the control unit, the ID-stage branch resolution and instruction memory, and feeds the IF/ID pipeline register.

---
 rtl/pc_ctrl_if.sv | 22 ++
 rtl/pc_ctrl.sv | 84 ++++++++
 tb/tb_pc_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: fetch-side bus between the PC sequencer, control/ID redirects and instruction memory.
interface pc_ctrl_if #(parameter int ADDR_W = 32);
  logic              stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic              if_ack;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              if_req;
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_valid_addr;
  modport master (
    input  stall, branch_flag, branch_target, flush, flush_target, if_ack,
    output pc, ce, if_req, pc_valid, pc_valid_addr
  );
  modport slave (
    output stall, branch_flag, branch_target, flush, flush_target, if_ack,
    input  pc, ce, if_req, pc_valid, pc_valid_addr
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: owns the program counter and sequences instruction fetches with redirect priority.
module pc_ctrl #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = 4
) (
  input logic        clk,
  input logic        rst,
  pc_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  typedef enum logic [1:0] {P_NONE, P_BRANCH, P_FLUSH} pend_t;
  state_t            state_q, state_d;
  pend_t             pend_q, pend_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] seq_pc, ack_tgt, hold_tgt;
  logic              redirect;
  // A fresh flush beats a pending one; any flush beats any branch.
  always_comb begin
    seq_pc   = pc_q + ADDR_W'(PC_STEP);
    ack_tgt  = bus.flush             ? bus.flush_target  :
               (pend_q == P_FLUSH)   ? pend_addr_q       :
               bus.branch_flag       ? bus.branch_target :
               (pend_q == P_BRANCH)  ? pend_addr_q       : seq_pc;
    hold_tgt = bus.flush ? bus.flush_target : bus.branch_flag ? bus.branch_target : pc_q;
    redirect = bus.flush | bus.branch_flag | (pend_q != P_NONE);
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    valid_d     = 1'b0;
    vaddr_d     = vaddr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.if_ack) begin
          valid_d = !redirect;
          vaddr_d = redirect ? vaddr_q : pc_q;
          pc_d    = ack_tgt;
          pend_d  = P_NONE;
          state_d = bus.stall ? HOLD : REQ;
        end else if (bus.flush) begin
          pend_d      = P_FLUSH;
          pend_addr_d = bus.flush_target;
        end else if (bus.branch_flag && pend_q != P_FLUSH) begin
          pend_d      = P_BRANCH;
          pend_addr_d = bus.branch_target;
        end
      end
      HOLD: begin
        pc_d    = hold_tgt;
        state_d = bus.stall ? HOLD : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      pend_q      <= P_NONE;
      pend_addr_q <= '0;
      valid_q     <= 1'b0;
      vaddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      valid_q     <= valid_d;
      vaddr_q     <= vaddr_d;
    end
  end
  assign bus.pc            = pc_q;
  assign bus.ce            = state_q != IDLE;
  assign bus.if_req        = state_q == REQ;
  assign bus.pc_valid      = valid_q;
  assign bus.pc_valid_addr = vaddr_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed vector table, corner sequences and randomized run against a reference model.
module tb_pc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pc_ctrl_if #(.ADDR_W(32)) bus();
  pc_ctrl #(.ADDR_W(32), .RESET_VEC(32'h0), .PC_STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  bit          m_run, m_hold, m_valid, m_pf, m_pb;
  logic [31:0] m_pc, m_vaddr, m_pfa, m_pba;
  typedef struct {
    bit s; bit br; logic [31:0] bt; bit fl; logic [31:0] ft; bit ack;
    logic [31:0] pc; bit req; bit v; logic [31:0] va;
  } vec_t;
  vec_t tbl[25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_hold = 0; m_valid = 0; m_pf = 0; m_pb = 0;
    m_pc = 32'h0; m_vaddr = 32'h0; m_pfa = 0; m_pba = 0;
  endtask
  // Rules applied at each rising edge using the inputs present before the edge.
  task automatic model_step();
    bit discard;
    m_valid = 0;
    if (!m_run) begin
      m_run = 1; m_hold = 0;
    end else if (m_hold) begin
      if (bus.flush) m_pc = bus.flush_target;
      else if (bus.branch_flag) m_pc = bus.branch_target;
      m_hold = bus.stall;
    end else if (bus.if_ack) begin
      discard = bus.flush | bus.branch_flag | m_pf | m_pb;
      if (!discard) begin m_valid = 1; m_vaddr = m_pc; end
      if (bus.flush) m_pc = bus.flush_target;
      else if (m_pf) m_pc = m_pfa;
      else if (bus.branch_flag) m_pc = bus.branch_target;
      else if (m_pb) m_pc = m_pba;
      else m_pc = m_pc + 32'd4;
      m_pf = 0; m_pb = 0;
      m_hold = bus.stall;
    end else if (bus.flush) begin
      m_pf = 1; m_pfa = bus.flush_target; m_pb = 0;
    end else if (bus.branch_flag && !m_pf) begin
      m_pb = 1; m_pba = bus.branch_target;
    end
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".ce"}, 32'(bus.ce), 32'(m_run));
    chk({tag, ".if_req"}, 32'(bus.if_req), 32'(m_run && !m_hold));
    chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".pc_valid_addr"}, bus.pc_valid_addr, m_vaddr);
  endtask
  task automatic drive(input bit s, input bit br, input logic [31:0] bt,
                       input bit fl, input logic [31:0] ft, input bit ack);
    bus.stall = s; bus.branch_flag = br; bus.branch_target = bt;
    bus.flush = fl; bus.flush_target = ft; bus.if_ack = ack;
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask
  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    chk({tag, ".pc"}, bus.pc, 32'h0);
    chk({tag, ".if_req"}, 32'(bus.if_req), 32'd0);
    chk({tag, ".ce"}, 32'(bus.ce), 32'd0);
    chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'd0);
    chk({tag, ".pc_valid_addr"}, bus.pc_valid_addr, 32'h0);
  endtask
  initial begin
    tbl[0]  = '{0,0,32'h0,0,32'h0,1, 32'h0,1,0,32'h0};
    tbl[1]  = '{0,0,32'h0,0,32'h0,1, 32'h4,1,1,32'h0};
    tbl[2]  = '{0,0,32'h0,0,32'h0,1, 32'h8,1,1,32'h4};
    tbl[3]  = '{0,0,32'h0,0,32'h0,1, 32'hC,1,1,32'h8};
    tbl[4]  = '{0,0,32'h0,0,32'h0,1, 32'h10,1,1,32'hC};
    tbl[5]  = '{0,1,32'h100,0,32'h0,0, 32'h10,1,0,32'h0};
    tbl[6]  = '{0,0,32'h0,0,32'h0,0, 32'h10,1,0,32'h0};
    tbl[7]  = '{0,0,32'h0,0,32'h0,1, 32'h100,1,0,32'h0};
    tbl[8]  = '{0,1,32'h200,1,32'h20,1, 32'h20,1,0,32'h0};
    tbl[9]  = '{0,0,32'h0,0,32'h0,1, 32'h24,1,1,32'h20};
    tbl[10] = '{1,0,32'h0,0,32'h0,0, 32'h24,1,0,32'h0};
    tbl[11] = '{1,0,32'h0,0,32'h0,1, 32'h28,0,1,32'h24};
    tbl[12] = '{1,0,32'h0,0,32'h0,0, 32'h28,0,0,32'h0};
    tbl[13] = '{1,0,32'h0,0,32'h0,1, 32'h28,0,0,32'h0};
    tbl[14] = '{0,0,32'h0,0,32'h0,0, 32'h28,1,0,32'h0};
    tbl[15] = '{0,0,32'h0,0,32'h0,1, 32'h2C,1,1,32'h28};
    tbl[16] = '{1,0,32'h0,0,32'h0,1, 32'h30,0,1,32'h2C};
    tbl[17] = '{1,1,32'hFFFF_FFF8,0,32'h0,0, 32'hFFFF_FFF8,0,0,32'h0};
    tbl[18] = '{0,0,32'h0,0,32'h0,0, 32'hFFFF_FFF8,1,0,32'h0};
    tbl[19] = '{0,0,32'h0,0,32'h0,1, 32'hFFFF_FFFC,1,1,32'hFFFF_FFF8};
    tbl[20] = '{0,0,32'h0,0,32'h0,1, 32'h0,1,1,32'hFFFF_FFFC};
    tbl[21] = '{0,0,32'h0,1,32'h80,0, 32'h0,1,0,32'h0};
    tbl[22] = '{0,1,32'h300,0,32'h0,0, 32'h0,1,0,32'h0};
    tbl[23] = '{0,0,32'h0,0,32'h0,1, 32'h80,1,0,32'h0};
    tbl[24] = '{0,0,32'h0,0,32'h0,1, 32'h84,1,1,32'h80};
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.pc_valid_addr", bus.pc_valid_addr, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].s, tbl[i].br, tbl[i].bt, tbl[i].fl, tbl[i].ft, tbl[i].ack);
      tick($sformatf("model[%0d]", i));
      chk($sformatf("vec[%0d].pc", i), bus.pc, tbl[i].pc);
      chk($sformatf("vec[%0d].if_req", i), 32'(bus.if_req), 32'(tbl[i].req));
      chk($sformatf("vec[%0d].pc_valid", i), 32'(bus.pc_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec[%0d].pc_valid_addr", i), bus.pc_valid_addr, tbl[i].va);
    end
    drive(0, 0, 0, 1, 32'h40, 1);
    tick("to40");
    chk("to40.pc", bus.pc, 32'h40);
    drive(0, 0, 0, 0, 0, 0);
    tick("wait40");
    #3;
    async_reset_check("async_rst");
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_model("rst_held");
    rst = 1'b1;
    tick("rst_release");
    chk("rst_release.pc", bus.pc, 32'h0);
    chk("rst_release.pc_valid", 32'(bus.pc_valid), 32'd0);
    tick("rst_first_ack");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        async_reset_check("rand_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 49) == 0) bus.branch_target = 32'hFFFF_FFFC;
      tick("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
